t07_esp_word_assembler: RTL and testbench

Parametrised successor to the fixed 4-bit ESP nibble input path. Collects IN_W-bit chunks from the ESP interface MSB-first into WORD_W-bit words and buffers completed words in a DEPTH-entry first-word-fall-through FIFO. The FIFO is drained by the register-file / memory-interface side through a valid/ready handshake. Adds per-chunk valid qualification, start-of-frame alignment, optional sync-wait mode, and sticky overflow and framing error flags.

---
 rtl/t07_esp_word_assembler.sv | 215 +++++++++++++++++++++
 tb/tb_t07_esp_word_assembler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/t07_esp_word_assembler.sv
// ESP word assembler.
// Collects IN_W-bit chunks, MSB-first, into WORD_W-bit words. Completed words
// go into a DEPTH-entry first-word-fall-through FIFO, which the consumer drains
// through a valid/ready handshake.
//
// Ports:
//   clk          rising-edge system clock
//   nrst         asynchronous active-low reset
//   esp_in       ESP chunk data
//   esp_valid    esp_in carries a chunk this cycle
//   esp_sof      qualified by esp_valid: this chunk is chunk 0 of a word
//   flush        synchronous clear of the assembler and FIFO (error flags kept)
//   err_clr      clears the sticky error flags; a new error in the same cycle wins
//   rd_en        consumer ready; a word is popped when word_valid is also 1
//   word_out     FIFO head word, 0 when the FIFO is empty
//   word_valid   FIFO not empty
//   fifo_count   number of stored words
//   full         fifo_count == DEPTH
//   overflow_err sticky: a completed word was dropped because the FIFO was full
//   frame_err    sticky: esp_sof arrived while a word was partially assembled
module t07_esp_word_assembler #(
  parameter int unsigned IN_W      = 4,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned SYNC_MODE = 0
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [IN_W-1:0]          esp_in,
  input  logic                     esp_valid,
  input  logic                     esp_sof,
  input  logic                     flush,
  input  logic                     err_clr,
  input  logic                     rd_en,
  output logic [WORD_W-1:0]        word_out,
  output logic                     word_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     full,
  output logic                     overflow_err,
  output logic                     frame_err
);

  localparam int unsigned Chunks = WORD_W / IN_W;
  localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam int unsigned PtrW   = $clog2(DEPTH);

  localparam logic [CntW-1:0] LastChunk = CntW'(Chunks - 1);
  localparam logic [PtrW:0]   DepthCnt  = (PtrW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    StSyncWait,
    StAssemble
  } state_e;

  // State entered after reset and flush.
  localparam state_e StInit = (SYNC_MODE != 0) ? StSyncWait : StAssemble;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   chunk_cnt_q, chunk_cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              frame_q, frame_d;

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              chunk_take;
  logic              sof_restart;
  logic [CntW-1:0]   cur_cnt;
  logic              word_done;
  logic [WORD_W-1:0] shift_next;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              drop;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StInit;
    end else if (state_q == StSyncWait && esp_valid && esp_sof) begin
      state_d = StAssemble;
    end
  end

  // FSM: outputs. In sync-wait only a sof chunk is accepted (as chunk 0).
  always_comb begin
    chunk_take = 1'b0;
    if (!flush && esp_valid) begin
      unique case (state_q)
        StSyncWait: chunk_take = esp_sof;
        StAssemble: chunk_take = 1'b1;
        default:    chunk_take = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Assembler datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // A sof chunk always restarts the word at chunk 0; older partial bits are
    // shifted out of the register before the word can complete.
    sof_restart = chunk_take && esp_sof && (state_q == StAssemble) && (chunk_cnt_q != '0);
    cur_cnt     = esp_sof ? '0 : chunk_cnt_q;
    word_done   = chunk_take && (cur_cnt == LastChunk);
    shift_next  = (shift_q << IN_W) | WORD_W'(esp_in);

    shift_d     = shift_q;
    chunk_cnt_d = chunk_cnt_q;
    if (flush) begin
      chunk_cnt_d = '0;
    end else if (chunk_take) begin
      shift_d     = shift_next;
      chunk_cnt_d = word_done ? '0 : cur_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shift_q     <= '0;
      chunk_cnt_q <= '0;
    end else begin
      shift_q     <= shift_d;
      chunk_cnt_q <= chunk_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DepthCnt);
    pop        = rd_en && !fifo_empty && !flush;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    push       = word_done && (!fifo_full || pop);
    drop       = word_done && fifo_full && !pop;

    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PtrW + 1)'(1);
        2'b01:   count_d = count_q - (PtrW + 1)'(1);
        default: count_d = count_q;
      endcase
    end

    overflow_d = (err_clr ? 1'b0 : overflow_q) | drop;
    frame_d    = (err_clr ? 1'b0 : frame_q) | sof_restart;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      frame_q    <= frame_d;
    end
  end

  // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    word_valid   = !fifo_empty;
    word_out     = fifo_empty ? '0 : mem_q[rd_ptr_q];
    fifo_count   = count_q;
    full         = fifo_full;
    overflow_err = overflow_q;
    frame_err    = frame_q;
  end

endmodule

// File: tb/tb_t07_esp_word_assembler.sv
module tb_t07_esp_word_assembler;

  logic        clk;
  logic        nrst;
  logic [3:0]  esp_in;
  logic        esp_sof;
  logic        flush;
  logic        err_clr;
  logic        esp_valid0, rd_en0;
  logic        esp_valid1, rd_en1;

  logic [31:0] word_out0, word_out1;
  logic        word_valid0, word_valid1;
  logic [5:0]  count0, count1;
  logic        full0, full1;
  logic        ovf0, ovf1;
  logic        ferr0, ferr1;

  int checks;
  int errors;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  // DUT 0: free-running assembly
  t07_esp_word_assembler #(
    .IN_W(4), .WORD_W(32), .DEPTH(32), .SYNC_MODE(0)
  ) dut0 (
    .clk(clk), .nrst(nrst), .esp_in(esp_in), .esp_valid(esp_valid0), .esp_sof(esp_sof),
    .flush(flush), .err_clr(err_clr), .rd_en(rd_en0), .word_out(word_out0),
    .word_valid(word_valid0), .fifo_count(count0), .full(full0), .overflow_err(ovf0),
    .frame_err(ferr0)
  );

  // DUT 1: sync-wait mode
  t07_esp_word_assembler #(
    .IN_W(4), .WORD_W(32), .DEPTH(32), .SYNC_MODE(1)
  ) dut1 (
    .clk(clk), .nrst(nrst), .esp_in(esp_in), .esp_valid(esp_valid1), .esp_sof(esp_sof),
    .flush(flush), .err_clr(err_clr), .rd_en(rd_en1), .word_out(word_out1),
    .word_valid(word_valid1), .fifo_count(count1), .full(full1), .overflow_err(ovf1),
    .frame_err(ferr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: compare the head word whenever the consumer takes one.
  always @(negedge clk) begin
    if (nrst && word_valid0 && rd_en0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop0_unexpected: got 0x%08h expected no word", word_out0);
      end else begin
        chk("pop0", word_out0, q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (nrst && word_valid1 && rd_en1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop1_unexpected: got 0x%08h expected no word", word_out1);
      end else begin
        chk("pop1", word_out1, q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [3:0] d, input logic sof);
    esp_in = d; esp_sof = sof; esp_valid0 = 1'b1;
    step();
    esp_valid0 = 1'b0; esp_sof = 1'b0;
  endtask

  task automatic send1(input logic [3:0] d, input logic sof);
    esp_in = d; esp_sof = sof; esp_valid1 = 1'b1;
    step();
    esp_valid1 = 1'b0; esp_sof = 1'b0;
  endtask

  task automatic word0(input logic [31:0] w);
    for (int i = 0; i < 8; i++) send0(w[31-4*i -: 4], 1'b0);
  endtask

  task automatic word1_sof(input logic [31:0] w);
    for (int i = 0; i < 8; i++) send1(w[31-4*i -: 4], (i == 0));
  endtask

  initial begin
    logic [31:0] w;
    checks = 0; errors = 0;
    nrst = 1'b0; esp_in = '0; esp_sof = 1'b0; flush = 1'b0; err_clr = 1'b0;
    esp_valid0 = 1'b0; rd_en0 = 1'b0; esp_valid1 = 1'b0; rd_en1 = 1'b0;
    repeat (2) step();
    chk("rst_valid0", {31'b0, word_valid0}, 32'd0);
    chk("rst_count0", {26'b0, count0}, 32'd0);
    chk("rst_word0", word_out0, 32'd0);
    chk("rst_flags0", {29'b0, full0, ovf0, ferr0}, 32'd0);
    nrst = 1'b1;
    step();

    // Back-to-back chunks A,A,B,B,C,C,D,D
    word0(32'hAABB_CCDD);
    q0.push_back(32'hAABB_CCDD);
    chk("w1_valid", {31'b0, word_valid0}, 32'd1);
    chk("w1_count", {26'b0, count0}, 32'd1);
    chk("w1_head", word_out0, 32'hAABB_CCDD);

    // Same word with a gap after every chunk
    for (int i = 0; i < 8; i++) begin
      w = 32'hAABB_CCDD;
      send0(w[31-4*i -: 4], 1'b0);
      step();
    end
    q0.push_back(32'hAABB_CCDD);
    chk("w2_count", {26'b0, count0}, 32'd2);

    // Fill to 33 words: the last one is dropped
    for (int i = 3; i <= 33; i++) begin
      word0(32'h1000_0000 + i);
      if (i <= 32) q0.push_back(32'h1000_0000 + i);
    end
    chk("ovf_count", {26'b0, count0}, 32'd32);
    chk("ovf_full", {31'b0, full0}, 32'd1);
    chk("ovf_flag", {31'b0, ovf0}, 32'd1);
    chk("ovf_head", word_out0, 32'hAABB_CCDD);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("ovf_clr", {31'b0, ovf0}, 32'd0);

    // Full FIFO, last chunk coincides with a pop: both happen
    w = 32'h5A5A_0F0F;
    for (int i = 0; i < 7; i++) send0(w[31-4*i -: 4], 1'b0);
    q0.push_back(w);
    rd_en0 = 1'b1;
    send0(w[3:0], 1'b0);
    rd_en0 = 1'b0;
    chk("pp_count", {26'b0, count0}, 32'd32);
    chk("pp_ovf", {31'b0, ovf0}, 32'd0);

    // Drain
    rd_en0 = 1'b1;
    repeat (32) step();
    rd_en0 = 1'b0;
    chk("drain_valid", {31'b0, word_valid0}, 32'd0);
    chk("drain_count", {26'b0, count0}, 32'd0);
    chk("drain_word", word_out0, 32'd0);

    // Framing error: 1,2,3 then sof 9 and seven zeros
    send0(4'h1, 1'b0); send0(4'h2, 1'b0); send0(4'h3, 1'b0);
    chk("pre_ferr", {31'b0, ferr0}, 32'd0);
    send0(4'h9, 1'b1);
    for (int i = 0; i < 7; i++) send0(4'h0, 1'b0);
    q0.push_back(32'h9000_0000);
    chk("ferr_set", {31'b0, ferr0}, 32'd1);
    chk("ferr_count", {26'b0, count0}, 32'd1);
    rd_en0 = 1'b1; step(); rd_en0 = 1'b0;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("ferr_clr", {31'b0, ferr0}, 32'd0);

    // Flush mid-word: partial word is discarded, next word aligns cleanly
    send0(4'hF, 1'b0); send0(4'hE, 1'b0); send0(4'hD, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    word0(32'h0123_4567);
    q0.push_back(32'h0123_4567);
    chk("flush_count", {26'b0, count0}, 32'd1);
    rd_en0 = 1'b1; step(); rd_en0 = 1'b0;

    // Sync mode: chunks before sof are ignored
    for (int i = 0; i < 5; i++) send1(4'(i + 3), 1'b0);
    chk("sync_ignore", {26'b0, count1}, 32'd0);
    word1_sof(32'h1234_5678);
    q1.push_back(32'h1234_5678);
    chk("sync_count", {26'b0, count1}, 32'd1);
    rd_en1 = 1'b1; step(); rd_en1 = 1'b0;

    // Reset with a stored word and a partial word in flight
    word1_sof(32'h0BAD_BEEF);
    send1(4'h5, 1'b1); send1(4'h6, 1'b0); send1(4'h7, 1'b0);
    chk("pre_rst_count", {26'b0, count1}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("rst1_valid", {31'b0, word_valid1}, 32'd0);
    chk("rst1_count", {26'b0, count1}, 32'd0);
    chk("rst1_word", word_out1, 32'd0);
    step();
    nrst = 1'b1;
    step();
    word1_sof(32'hCAFE_F00D);
    q1.push_back(32'hCAFE_F00D);
    chk("post_rst_count", {26'b0, count1}, 32'd1);
    chk("post_rst_ferr", {31'b0, ferr1}, 32'd0);
    rd_en1 = 1'b1; step(); rd_en1 = 1'b0;
    step();

    chk("q0_left", q0.size(), 32'd0);
    chk("q1_left", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
